// File: rtl/pl_bit_pkg.sv
// Shared definitions for the bit-RAM readout path.
// Provides the readout FSM state encoding and the default output word width.
package pl_bit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int DEF_WORD_W = 32;

endpackage

// File: rtl/bit_word_packer.sv
// Serial-bit to word packer with an output holding register.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   bit_vld_i/bit_i     one incoming bit per cycle (LSB of the word first)
//   bit_last_i          incoming bit is the final bit of the burst
//   issue_ok_o          a bit issued now can be stored when it arrives
//   m_tdata_o/m_tvalid_o/m_tready_i/m_tlast_o  valid/ready word output
module bit_word_packer
    import pl_bit_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              bit_vld_i,
    input  logic              bit_i,
    input  logic              bit_last_i,
    output logic              issue_ok_o,
    output logic [WORD_W-1:0] m_tdata_o,
    output logic              m_tvalid_o,
    input  logic              m_tready_i,
    output logic              m_tlast_o
);

    localparam int CNT_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

    logic [WORD_W-1:0] acc_q, acc_d, out_q, out_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              acc_done_q, acc_done_d, acc_last_q, acc_last_d;
    logic              out_vld_q, out_vld_d, out_last_q, out_last_d;

    logic              out_free, xfer_old, xfer_new, complete;
    logic [WORD_W-1:0] b_acc, n_acc;
    logic [CNT_W-1:0]  b_cnt, n_cnt;

    always_comb begin
        out_free = !out_vld_q || m_tready_i;
        // A completed word parked in the accumulator moves out first.
        xfer_old = acc_done_q && out_free;
        b_acc    = xfer_old ? '0 : acc_q;
        b_cnt    = xfer_old ? '0 : cnt_q;
        n_acc    = b_acc | (WORD_W'(bit_i) << b_cnt);
        n_cnt    = b_cnt + CNT_W'(1);
        complete = (n_cnt == CNT_FULL) || bit_last_i;
        // The completing bit goes straight to the output on the same edge.
        xfer_new = bit_vld_i && complete && !xfer_old && out_free;

        acc_d      = acc_q;
        cnt_d      = cnt_q;
        acc_done_d = acc_done_q;
        acc_last_d = acc_last_q;
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        out_last_d = out_last_q;

        if (xfer_old) begin
            out_d      = acc_q;
            out_last_d = acc_last_q;
            out_vld_d  = 1'b1;
        end else if (xfer_new) begin
            out_d      = n_acc;
            out_last_d = bit_last_i;
            out_vld_d  = 1'b1;
        end else if (m_tready_i) begin
            out_vld_d  = 1'b0;
        end

        if (xfer_new) begin
            acc_d      = '0;
            cnt_d      = '0;
            acc_done_d = 1'b0;
            acc_last_d = 1'b0;
        end else if (bit_vld_i) begin
            acc_d      = n_acc;
            cnt_d      = n_cnt;
            acc_done_d = complete;
            acc_last_d = bit_last_i;
        end else if (xfer_old) begin
            acc_d      = '0;
            cnt_d      = '0;
            acc_done_d = 1'b0;
            acc_last_d = 1'b0;
        end

        // A bit issued now lands one edge after the next; refuse if the
        // accumulator may still hold a complete unsent word by then.
        issue_ok_o = !((acc_done_q && !out_free) ||
                       (bit_vld_i && !acc_done_q && cnt_q == CNT_LAST && !out_free));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            acc_done_q <= 1'b0;
            acc_last_q <= 1'b0;
            out_q      <= '0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            acc_done_q <= acc_done_d;
            acc_last_q <= acc_last_d;
            out_q      <= out_d;
            out_vld_q  <= out_vld_d;
            out_last_q <= out_last_d;
        end
    end

    assign m_tdata_o  = out_q;
    assign m_tvalid_o = out_vld_q;
    assign m_tlast_o  = out_last_q;

endmodule

// File: rtl/bit_ram_word_reader.sv
// Reads a burst of bits from the 1-bit capture RAM and streams them out
// packed LSB-first into WORD_W-bit words.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   start_i/start_addr_i/nbits_i burst command (sampled in IDLE)
//   busy_o, done_o               burst in progress / one-cycle completion
//   ram_raddr_o, ram_rdata_i     RAM read port, 1-cycle read latency
//   m_tdata_o/m_tvalid_o/m_tready_i/m_tlast_o  word stream
module bit_ram_word_reader
    import pl_bit_pkg::*;
#(
    parameter int DEPTH  = 8192,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int WORD_W = DEF_WORD_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] start_addr_i,
    input  logic [ADDR_W:0]   nbits_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] ram_raddr_o,
    input  logic              ram_rdata_i,
    output logic [WORD_W-1:0] m_tdata_o,
    output logic              m_tvalid_o,
    input  logic              m_tready_i,
    output logic              m_tlast_o
);

    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_TOP = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   issued_q, issued_d, total_q, total_d;
    logic              pend_q, pend_d, pend_last_q, pend_last_d;
    logic              done_q, done_d;
    logic [ADDR_W:0]   nbits_sat;
    logic              issue_ok, final_hs;

    assign nbits_sat = (nbits_i > DEPTH_C) ? DEPTH_C : nbits_i;
    assign final_hs  = m_tvalid_o && m_tready_i && m_tlast_o;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        issued_d    = issued_q;
        total_d     = total_q;
        pend_d      = 1'b0;
        pend_last_d = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (nbits_sat == '0) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d   = start_addr_i;
                        issued_d = '0;
                        total_d  = nbits_sat;
                        state_d  = RUN;
                    end
                end
            end
            RUN: begin
                // The read of addr_q is in flight this cycle; data is
                // captured by the packer one edge after pend_q rises.
                if (issue_ok) begin
                    pend_d   = 1'b1;
                    addr_d   = (addr_q == ADDR_TOP) ? '0 : addr_q + ADDR_W'(1);
                    issued_d = issued_q + CNT_ONE;
                    if (issued_q + CNT_ONE == total_q) begin
                        pend_last_d = 1'b1;
                        state_d     = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (final_hs) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            issued_q    <= '0;
            total_q     <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            issued_q    <= issued_d;
            total_q     <= total_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
            done_q      <= done_d;
        end
    end

    bit_word_packer #(.WORD_W(WORD_W)) u_packer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .bit_vld_i  (pend_q),
        .bit_i      (ram_rdata_i),
        .bit_last_i (pend_last_q),
        .issue_ok_o (issue_ok),
        .m_tdata_o  (m_tdata_o),
        .m_tvalid_o (m_tvalid_o),
        .m_tready_i (m_tready_i),
        .m_tlast_o  (m_tlast_o)
    );

    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;
    assign ram_raddr_o = addr_q;

endmodule
